// File: rtl/controle_multiciclo_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : controle_multiciclo_if                             |
// | Description : Bundle between the multicycle MIPS main control    |
// |               unit and its datapath: opcode and memory-ready in, |
// |               every datapath enable/select plus debug state out. |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
interface controle_multiciclo_if;
  logic [5:0] opcode;
  logic       memPronto;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic [1:0] PCSource;
  logic [1:0] ALUSrcB;
  logic [1:0] aluOp;
  logic       opIlegal;
  logic [3:0] estado;

  // Control unit side
  modport master (
    input  opcode, memPronto,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
           IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
           aluOp, opIlegal, estado
  );

  // Datapath side
  modport slave (
    output opcode, memPronto,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
           IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
           aluOp, opIlegal, estado
  );
endinterface
`default_nettype wire

// File: rtl/controle_multiciclo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : controle_multiciclo                                |
// | Description : Moore main control FSM for the multicycle MIPS     |
// |               datapath (fetch/decode/exec/mem/writeback) with    |
// |               memory wait states via memPronto.                  |
// |               Optional macro MIPS_ADDI_EN enables addi decoding. |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module controle_multiciclo (
  input  logic                  clock,
  input  logic                  reset,
  controle_multiciclo_if.master bus
);

  localparam logic [3:0] INIT   = 4'd15;
  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] JUMP   = 4'd9;
`ifdef MIPS_ADDI_EN
  localparam logic [3:0] ADDIEX = 4'd10;
  localparam logic [3:0] ADDIWB = 4'd11;
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       op_legal;

  // Flags opcodes this control unit knows how to sequence
  always_comb begin
    op_legal = 1'b0;
    case (bus.opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef MIPS_ADDI_EN
      OP_ADDI:                              op_legal = 1'b1;
`endif
      default:                              op_legal = 1'b0;
    endcase
  end

  // State register; reset drops to INIT at once, even mid-instruction
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= next_state;
  end

  // Next-state logic; memPronto only gates the three memory-access states
  always_comb begin
    next_state = FETCH;
    case (state)
      INIT:   next_state = FETCH;
      FETCH:  next_state = bus.memPronto ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
`ifdef MIPS_ADDI_EN
          OP_ADDI:      next_state = ADDIEX;
`endif
          default:      next_state = FETCH;
        endcase
      end
      MEMADR: begin
        if (bus.opcode == OP_LW)      next_state = MEMRD;
        else if (bus.opcode == OP_SW) next_state = MEMWR;
        else                          next_state = FETCH;
      end
      MEMRD:  next_state = bus.memPronto ? MEMWB : MEMRD;
      MEMWR:  next_state = bus.memPronto ? FETCH : MEMWR;
      EXEC:   next_state = ALUWB;
`ifdef MIPS_ADDI_EN
      ADDIEX: next_state = ADDIWB;
`endif
      // MEMWB, ALUWB, BRANCH, JUMP, ADDIWB and unused codes return to fetch
      default: next_state = FETCH;
    endcase
  end

  // Output decode; only IRWrite/PCWrite in FETCH look at memPronto
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.PCSource    = 2'b00;
    bus.ALUSrcB     = 2'b00;
    bus.aluOp       = 2'b00;
    bus.opIlegal    = 1'b0;
    case (state)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.memPronto;
        bus.PCWrite = bus.memPronto;
      end
      DECODE: begin
        bus.ALUSrcB  = 2'b11;
        bus.opIlegal = ~op_legal;
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.aluOp   = 2'b10;
      end
      ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.aluOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
`ifdef MIPS_ADDI_EN
      ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      ADDIWB: begin
        bus.RegWrite = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.estado = state;

endmodule
`default_nettype wire

// File: tb/tb_controle_multiciclo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_controle_multiciclo                             |
// | Description : Directed bench for controle_multiciclo; walks each |
// |               instruction class with hand-computed state and     |
// |               control-word expectations. Honours MIPS_ADDI_EN.   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_controle_multiciclo;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  controle_multiciclo_if bus ();

  controle_multiciclo dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  // Observed control word:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,
  //  RegWrite,RegDst,PCSource[1:0],ALUSrcB[1:0],aluOp[1:0],opIlegal}
  logic [16:0] ctl_obs;
  assign ctl_obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                    bus.MemWrite, bus.MemtoReg, bus.IRWrite, bus.ALUSrcA,
                    bus.RegWrite, bus.RegDst, bus.PCSource, bus.ALUSrcB,
                    bus.aluOp, bus.opIlegal};

  // Hand-written expected words, same bit order as above
  localparam logic [16:0] C_ZERO  = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_FET1  = 17'b1_0_0_1_0_0_1_0_0_0_00_01_00_0;
  localparam logic [16:0] C_FET0  = 17'b0_0_0_1_0_0_0_0_0_0_00_01_00_0;
  localparam logic [16:0] C_DEC   = 17'b0_0_0_0_0_0_0_0_0_0_00_11_00_0;
  localparam logic [16:0] C_DECX  = 17'b0_0_0_0_0_0_0_0_0_0_00_11_00_1;
  localparam logic [16:0] C_MADR  = 17'b0_0_0_0_0_0_0_1_0_0_00_10_00_0;
  localparam logic [16:0] C_MRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MWB   = 17'b0_0_0_0_0_1_0_0_1_0_00_00_00_0;
  localparam logic [16:0] C_MWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_EXEC  = 17'b0_0_0_0_0_0_0_1_0_0_00_00_10_0;
  localparam logic [16:0] C_ALUWB = 17'b0_0_0_0_0_0_0_0_1_1_00_00_00_0;
  localparam logic [16:0] C_BR    = 17'b0_1_0_0_0_0_0_1_0_0_01_00_01_0;
  localparam logic [16:0] C_JMP   = 17'b1_0_0_0_0_0_0_0_0_0_10_00_00_0;
  localparam logic [16:0] C_ADDEX = 17'b0_0_0_0_0_0_0_1_0_0_00_10_00_0;
  localparam logic [16:0] C_ADDWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_ADI = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  // Single comparison point: counts and reports mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, apply this cycle's inputs, then check state and controls
  task automatic cyc(input string tag, input logic [5:0] op, input logic mp,
                     input logic [3:0] exp_st, input logic [16:0] exp_ctl);
    @(posedge clock);
    #1;
    bus.opcode    = op;
    bus.memPronto = mp;
    #1;
    check({tag, "_st"},  {28'd0, bus.estado}, {28'd0, exp_st});
    check({tag, "_ctl"}, {15'd0, ctl_obs},    {15'd0, exp_ctl});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.opcode    = OP_R;
    bus.memPronto = 1'b1;
    reset         = 1'b0;
    #12;
    check("rst_st",  {28'd0, bus.estado}, 32'd15);
    check("rst_ctl", {15'd0, ctl_obs},    {15'd0, C_ZERO});
    @(negedge clock);
    reset = 1'b1;

    cyc("start_fetch", OP_R, 1'b1, 4'd0, C_FET1);

    // R-type; memPronto low in EXEC must be ignored
    cyc("r_dec",   OP_R, 1'b1, 4'd1, C_DEC);
    cyc("r_exec",  OP_R, 1'b0, 4'd6, C_EXEC);
    cyc("r_aluwb", OP_R, 1'b1, 4'd7, C_ALUWB);
    cyc("r_fetch", OP_R, 1'b1, 4'd0, C_FET1);

    // lw with two MEMRD wait cycles
    cyc("lw_dec",  OP_LW, 1'b1, 4'd1, C_DEC);
    cyc("lw_madr", OP_LW, 1'b1, 4'd2, C_MADR);
    cyc("lw_rd0",  OP_LW, 1'b0, 4'd3, C_MRD);
    cyc("lw_rd1",  OP_LW, 1'b0, 4'd3, C_MRD);
    cyc("lw_rd2",  OP_LW, 1'b1, 4'd3, C_MRD);
    cyc("lw_wb",   OP_LW, 1'b1, 4'd4, C_MWB);
    cyc("lw_fetch",OP_LW, 1'b1, 4'd0, C_FET1);

    // beq
    cyc("beq_dec", OP_BEQ, 1'b1, 4'd1, C_DEC);
    cyc("beq_br",  OP_BEQ, 1'b1, 4'd8, C_BR);
    cyc("beq_fetch",OP_BEQ, 1'b1, 4'd0, C_FET1);

    // j, then three FETCH wait cycles with no writes
    cyc("j_dec",   OP_J, 1'b1, 4'd1, C_DEC);
    cyc("j_jmp",   OP_J, 1'b1, 4'd9, C_JMP);
    cyc("wait_f0", OP_J, 1'b0, 4'd0, C_FET0);
    cyc("wait_f1", OP_J, 1'b0, 4'd0, C_FET0);
    cyc("wait_f2", OP_J, 1'b0, 4'd0, C_FET0);
    cyc("wait_f3", OP_J, 1'b1, 4'd0, C_FET1);

    // Illegal opcode
    cyc("ill_dec",  OP_BAD, 1'b1, 4'd1, C_DECX);
    cyc("ill_fetch",OP_BAD, 1'b1, 4'd0, C_FET1);

    // addi, configuration dependent
`ifdef MIPS_ADDI_EN
    cyc("addi_dec", OP_ADI, 1'b1, 4'd1,  C_DEC);
    cyc("addi_ex",  OP_ADI, 1'b1, 4'd10, C_ADDEX);
    cyc("addi_wb",  OP_ADI, 1'b1, 4'd11, C_ADDWB);
`else
    cyc("addi_dec", OP_ADI, 1'b1, 4'd1,  C_DECX);
`endif
    cyc("addi_fetch", OP_ADI, 1'b1, 4'd0, C_FET1);

    // MEMADR with an opcode that is neither lw nor sw falls back to fetch
    cyc("madr_dec",  OP_LW, 1'b1, 4'd1, C_DEC);
    cyc("madr_x",    OP_R,  1'b1, 4'd2, C_MADR);
    cyc("madr_fetch",OP_R,  1'b1, 4'd0, C_FET1);

    // sw stalled in MEMWR, then asynchronous reset mid-cycle
    cyc("sw_dec",  OP_SW, 1'b1, 4'd1, C_DEC);
    cyc("sw_madr", OP_SW, 1'b1, 4'd2, C_MADR);
    cyc("sw_wr0",  OP_SW, 1'b0, 4'd5, C_MWR);
    cyc("sw_wr1",  OP_SW, 1'b0, 4'd5, C_MWR);
    #1;
    reset = 1'b0;
    #1;
    check("arst_st",  {28'd0, bus.estado},   32'd15);
    check("arst_mw",  {31'd0, bus.MemWrite}, 32'd0);
    check("arst_ctl", {15'd0, ctl_obs},      {15'd0, C_ZERO});
    @(negedge clock);
    reset = 1'b1;
    cyc("arst_fetch", OP_SW, 1'b1, 4'd0, C_FET1);

    // sw completing normally after one wait
    cyc("sw2_dec",  OP_SW, 1'b1, 4'd1, C_DEC);
    cyc("sw2_madr", OP_SW, 1'b1, 4'd2, C_MADR);
    cyc("sw2_wr0",  OP_SW, 1'b0, 4'd5, C_MWR);
    cyc("sw2_wr1",  OP_SW, 1'b1, 4'd5, C_MWR);
    cyc("sw2_fetch",OP_SW, 1'b1, 4'd0, C_FET1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controle_multiciclo.md
# controle_multiciclo

Main control unit for the multicycle MIPS datapath: a Moore-style finite state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, including the 2-bit `aluOp` consumed by the ALU control decoder. It sits between the instruction register (opcode source) and the datapath. Memory accesses wait for a ready handshake, so slow memories are supported.

## Interface
- No parameters. State encoding is fixed, 4 bits.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous reset, active-low.
- `opcode` in 6: IR[31:26]; sampled only in DECODE and MEMADR.
- `memPronto` in 1: memory ready. 1 means the current read or write completes this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst` out 1 each: datapath enables and selects.
- `PCSource` out 2: PC mux select. 00 = ALU, 01 = ALUOut, 10 = jump target.
- `ALUSrcB` out 2: ALU B mux select. 00 = reg B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `aluOp` out 2: 00 = add, 01 = subtract, 10 = decode the funct field.
- `opIlegal` out 1: high during DECODE when the opcode is unsupported.
- `estado` out 4: current state, for debug.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000 (addi only when the configuration macro below is defined).
- State codes:
  - INIT = 15, FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXEC = 6, ALUWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11
  - Codes 12–14 are unused.
- Outputs per state. Any output not listed is 0.
  - INIT: all outputs 0.
  - FETCH: MemRead = 1, ALUSrcB = 01, aluOp = 00. IRWrite = PCWrite = memPronto (the only Mealy terms).
  - DECODE: ALUSrcB = 11, aluOp = 00.
  - MEMADR: ALUSrcA = 1, ALUSrcB = 10, aluOp = 00.
  - MEMRD: MemRead = 1, IorD = 1.
  - MEMWB: MemtoReg = 1, RegWrite = 1.
  - MEMWR: MemWrite = 1, IorD = 1.
  - EXEC: ALUSrcA = 1, ALUSrcB = 00, aluOp = 10.
  - ALUWB: RegDst = 1, RegWrite = 1.
  - BRANCH: ALUSrcA = 1, aluOp = 01, PCWriteCond = 1, PCSource = 01.
  - JUMP: PCWrite = 1, PCSource = 10.
  - ADDIEX: ALUSrcA = 1, ALUSrcB = 10, aluOp = 00.
  - ADDIWB: RegWrite = 1, RegDst = 0, MemtoReg = 0.
- Transitions:
  - INIT → FETCH, unconditionally.
  - FETCH stays in FETCH while memPronto = 0, then → DECODE.
  - DECODE, by opcode: lw or sw → MEMADR; R-type → EXEC; beq → BRANCH; j → JUMP; addi → ADDIEX.
  - DECODE with any other opcode: opIlegal = 1, → FETCH.
  - MEMADR: lw → MEMRD; sw → MEMWR; any other opcode → FETCH.
  - MEMRD stays in MEMRD while memPronto = 0, then → MEMWB.
  - MEMWR stays in MEMWR while memPronto = 0, then → FETCH.
  - MEMWB, ALUWB, BRANCH, JUMP, ADDIWB → FETCH.
  - EXEC → ALUWB.
  - ADDIEX → ADDIWB.
- Unused codes 12–14 → FETCH on the next edge, with all outputs 0 while in them.
- memPronto is ignored in every state except FETCH, MEMRD and MEMWR.

## Timing
- State register updates on the rising edge of `clock`. Outputs decode combinationally from state; only IRWrite and PCWrite in FETCH also depend on memPronto.
- Reset:
  - `reset` = 0 forces INIT immediately, asynchronously, even mid-instruction (e.g. during a MEMWR wait).
  - All outputs read 0 and `estado` = 1111.
  - On the first rising edge after `reset` goes to 1, the state becomes FETCH.
- Cycles per instruction with memPronto held at 1, counted from FETCH entry back to FETCH entry:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal opcode 2.
- Each cycle memPronto is low in FETCH, MEMRD or MEMWR adds one cycle.
- Nothing is written while waiting: IRWrite and PCWrite stay 0 until memPronto = 1.
- opcode must be stable from the DECODE cycle through MEMADR (the IR is not rewritten outside FETCH).

## Configuration
- `MIPS_ADDI_EN`
  - Defined: opcode 001000 is decoded, DECODE → ADDIEX → ADDIWB, and states 10 and 11 exist.
  - Undefined: 001000 is illegal (opIlegal = 1 in DECODE, → FETCH). States 10 and 11 are unused codes and behave like 12–14.

## Test plan
- Reset and start:
  - Hold `reset` = 0 → estado = 1111, all outputs 0.
  - Release → next edge estado = 0000 with MemRead = 1, ALUSrcB = 01, aluOp = 00.
- R-type (opcode 000000), memPronto = 1:
  - Sequence 0 → 1 → 6 → 7 → 0.
  - aluOp = 10 in EXEC; RegDst = 1 and RegWrite = 1 in ALUWB.
- lw (100011) with memPronto low for 2 cycles in MEMRD:
  - Sequence 0 → 1 → 2 → 3 → 3 → 3 → 4 → 0.
  - MemtoReg = 1 and RegWrite = 1 only in state 4.
- beq (000100) and j (000010):
  - beq: 0 → 1 → 8 → 0, with aluOp = 01, PCWriteCond = 1, PCSource = 01 in state 8.
  - j: 0 → 1 → 9 → 0, with PCWrite = 1, PCSource = 10 in state 9.
- Wait-state integrity: memPronto = 0 for 3 cycles in FETCH → IRWrite = PCWrite = 0 throughout; both go to 1 in the cycle memPronto rises.
- Illegal and async reset:
  - Opcode 111111 → opIlegal = 1 in DECODE, then state 0.
  - sw stalled in state 5, then `reset` pulsed low between edges → estado = 1111 and MemWrite = 0 immediately.
  - Repeat opcode 001000 with and without `MIPS_ADDI_EN`: defined → 1 → 10 → 11 → 0; undefined → opIlegal = 1, → 0.
